// File: rtl/dsound_dma_sched.sv
//-----------------------------------------------------------------------------
// dsound_dma_sched
//
// Refill scheduler for the two direct-sound FIFOs (channel A and B). Each
// channel raises a refill request. The scheduler picks one channel, presents
// a burst request to the DMA engine, and counts the words written into that
// channel's FIFO until the burst is complete.
//
// Parameters
//   BURST_WORDS     32-bit words per refill burst (1..8)
//   TIMEOUT_CYCLES  watchdog limit in clock cycles (watchdog builds only)
//
// Optional feature
//   DSOUND_SCHED_TIMEOUT_EN  when defined, a watchdog aborts a burst that
//                            stalls for TIMEOUT_CYCLES clock cycles. When
//                            undefined, timeout_err is tied low and the
//                            scheduler waits indefinitely.
//
// Ports
//   clock        system clock, all state on the rising edge
//   reset_n      asynchronous active-low reset
//   req_a/req_b  refill requests (single-cycle pulse or level)
//   clr_a/clr_b  FIFO clear (sequencer reset) for each channel
//   dma_gnt      DMA engine accepts the current dma_req
//   word_done    DMA wrote one word into the FIFO selected by dma_ch
//   dma_req      registered burst request to the DMA engine
//   dma_ch       target channel (0 = A, 1 = B), stable while dma_req or busy
//   busy         high while a burst is requested or in flight
//   timeout_err  one-cycle pulse when the watchdog aborts a burst
//-----------------------------------------------------------------------------
`timescale 1ns/1ps

module dsound_dma_sched #(
    parameter int BURST_WORDS    = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset_n,
    input  logic req_a,
    input  logic req_b,
    input  logic clr_a,
    input  logic clr_b,
    input  logic dma_gnt,
    input  logic word_done,
    output logic dma_req,
    output logic dma_ch,
    output logic busy,
    output logic timeout_err
);

    if (BURST_WORDS < 1 || BURST_WORDS > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("dsound_dma_sched: BURST_WORDS must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_XFER = 2'd2
    } state_t;

    localparam logic [2:0] LAST_WORD = 3'(BURST_WORDS - 1);

    state_t     state_q,   state_d;
    logic [1:0] pend_q,    pend_d;     // bit 0 = channel A, bit 1 = channel B
    logic       rr_q,      rr_d;       // channel favoured when both are pending
    logic       dma_ch_q,  dma_ch_d;
    logic [2:0] cnt_q,     cnt_d;      // words written in the current burst
    logic       dma_req_q, dma_req_d;
    logic       busy_q,    busy_d;

    logic [1:0] req_v;
    logic [1:0] clr_v;
    logic [1:0] elig_v;
    logic [1:0] active_v;
    logic [1:0] retire_v;
    logic       retire;
    logic       abort;
    logic       clr_sel;
    logic       wd_expired;

    assign req_v   = {req_b, req_a};
    assign clr_v   = {clr_b, clr_a};
    assign clr_sel = clr_v[dma_ch_q];

    // A clear in the same cycle wins over a pending flag, so a channel being
    // cleared is never selected.
    assign elig_v   = pend_q & ~clr_v;
    assign active_v = (state_q != S_IDLE) ? (dma_ch_q ? 2'b10 : 2'b01) : 2'b00;
    assign retire_v = retire ? (dma_ch_q ? 2'b10 : 2'b01) : 2'b00;

    // NOTE: every signal written in always_comb gets a default first, so no
    // latch can be inferred on a path that forgets to assign it.
    always_comb begin
        state_d  = state_q;
        dma_ch_d = dma_ch_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        retire   = 1'b0;
        abort    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (elig_v != 2'b00) begin
                    state_d  = S_REQ;
                    // Both pending: take the favoured one; otherwise the only one.
                    dma_ch_d = (elig_v == 2'b11) ? rr_q : elig_v[1];
                end
            end

            S_REQ: begin
                // A clear of the selected channel beats a grant in the same cycle.
                if (clr_sel) begin
                    state_d = S_IDLE;
                end else if (dma_gnt) begin
                    state_d = S_XFER;
                    cnt_d   = '0;
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end

            S_XFER: begin
                // A clear here does not stop the burst: the DMA engine owns the
                // bus until the last word lands.
                if (word_done) begin
                    if (cnt_q == LAST_WORD) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        retire  = 1'b1;
                        rr_d    = ~dma_ch_q;
                    end else begin
                        cnt_d = cnt_q + 3'd1;
                    end
                end else if (wd_expired) begin
                    abort = 1'b1;
                end
            end

            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            retire  = 1'b1;
            rr_d    = ~dma_ch_q;
        end
    end

    // The favoured channel becomes the one not served last, which flips the
    // pointer whenever the favoured channel itself was served.
    always_comb begin
        // A request for the channel already in flight is dropped; the other
        // channel's request queues as a pending flag.
        pend_d    = (pend_q | (req_v & ~active_v)) & ~retire_v & ~clr_v;
        dma_req_d = (state_d == S_REQ);
        busy_d    = (state_d != S_IDLE);
    end

    // NOTE: sequential state is updated with non-blocking assignments only, so
    // every flop samples the values present before the clock edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            pend_q    <= 2'b00;
            rr_q      <= 1'b0;
            dma_ch_q  <= 1'b0;
            cnt_q     <= '0;
            dma_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            rr_q      <= rr_d;
            dma_ch_q  <= dma_ch_d;
            cnt_q     <= cnt_d;
            dma_req_q <= dma_req_d;
            busy_q    <= busy_d;
        end
    end

    assign dma_req = dma_req_q;
    assign dma_ch  = dma_ch_q;
    assign busy    = busy_q;

`ifdef DSOUND_SCHED_TIMEOUT_EN
    localparam int              WD_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_q, wd_d;
    logic            timeout_err_q;

    // wd_q counts cycles already spent without progress; the cycle in which it
    // reads TIMEOUT_CYCLES-1 is the last one allowed.
    assign wd_expired = (wd_q == WD_LAST);

    always_comb begin
        wd_d = '0;
        if (state_q != S_IDLE && state_d == state_q &&
            !(state_q == S_XFER && word_done)) begin
            wd_d = wd_q + WD_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= abort;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign wd_expired  = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/dsound_dma_sched.md
DSOUND_DMA_SCHED -- requirements
Module: dsound_dma_sched

Interface
REQ-001 SHALL have parameter BURST_WORDS, default 4, meaning 32-bit words written per FIFO refill burst (legal range 1..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning watchdog limit in clock cycles (used only under REQ-026).
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 clock  in  1  system clock, all state on rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 req_a  in  1  refill request from direct-sound channel A (sound_req), single-cycle or level.
REQ-007 req_b  in  1  refill request from direct-sound channel B.
REQ-008 clr_a  in  1  channel A FIFO clear (sequencer_reset).
REQ-009 clr_b  in  1  channel B FIFO clear.
REQ-010 dma_gnt  in  1  DMA engine accepts the current dma_req.
REQ-011 word_done  in  1  DMA wrote one word into the FIFO selected by dma_ch.
REQ-012 dma_req  out  1  refill burst request to DMA engine.
REQ-013 dma_ch  out  1  target channel: 0 = A, 1 = B; stable while dma_req or busy.
REQ-014 busy  out  1  high in REQ and XFER states.
REQ-015 timeout_err  out  1  one-cycle pulse on watchdog abort.

Function
REQ-016 SHALL keep per-channel pending flags: set on req_x high, cleared on clr_x, on burst completion for that channel, or on abort; clr_x wins over simultaneous req_x.
REQ-017 SHALL implement FSM states IDLE, REQ, XFER.
REQ-018 IDLE: if any pending flag set, select channel, load dma_ch, enter REQ next cycle; dma_req registered, high first cycle in REQ.
REQ-019 Selection SHALL be round-robin: if both pending, grant the channel not served last; rr pointer updates only on burst completion.
REQ-020 REQ: hold dma_req high until dma_gnt sampled high, then enter XFER with word counter = 0 and dma_req low next cycle.
REQ-021 REQ: clr of selected channel SHALL drop dma_req and return to IDLE next cycle (dma_gnt in same cycle as clr is ignored).
REQ-022 XFER: each word_done increments counter; word_done with counter == BURST_WORDS-1 SHALL return to IDLE, clear that channel's pending flag, flip rr pointer.
REQ-023 XFER: clr of active channel SHALL NOT abort the burst (DMA owns the bus); pending flag is cleared and a req in the same cycle is discarded.
REQ-024 New req for the active channel during REQ/XFER SHALL be ignored for that channel (burst already in flight); req for the other channel SHALL be queued.
REQ-025 word_done outside XFER SHALL be ignored; counter width SHALL be 3 bits, no wrap beyond BURST_WORDS-1.

Configuration
REQ-026 With DSOUND_SCHED_TIMEOUT_EN defined: cycle counter runs in REQ/XFER, resets on state entry and on each word_done; reaching TIMEOUT_CYCLES SHALL force IDLE, drop dma_req, clear the active channel's pending flag, pulse timeout_err for one cycle, flip rr pointer.
REQ-027 Without DSOUND_SCHED_TIMEOUT_EN: no watchdog logic, timeout_err tied 0, REQ/XFER wait indefinitely.

Reset
REQ-028 reset_n low SHALL asynchronously force IDLE, pending flags 0, counters 0, rr pointer to A, dma_req 0, dma_ch 0, busy 0, timeout_err 0.
REQ-029 Reset mid-burst SHALL abandon the burst with no completion side effects; first request after release sampled on first rising edge with reset_n high.

Verification
REQ-030 req_a pulse, dma_gnt 2 cycles after dma_req, 4 word_done -> dma_ch=0, busy high for 1+2+4 burst cycles, IDLE after 4th word_done.
REQ-031 req_a and req_b same cycle, rr at A -> A burst then B burst, dma_ch 0 then 1; repeat -> A granted first again.
REQ-032 req_b, clr_b during REQ before dma_gnt -> dma_req low next cycle, busy low, no XFER.
REQ-033 clr_a after 2nd word_done of A burst -> burst completes at 4 words, no re-request of A.
REQ-034 reset_n low after 1 word_done -> all outputs 0 immediately; post-release req_b -> fresh burst, dma_ch=1.
REQ-035 With DSOUND_SCHED_TIMEOUT_EN, TIMEOUT_CYCLES=16, no dma_gnt -> timeout_err pulse 16 cycles after REQ entry, dma_req low; without macro dma_req stays high 100 cycles.
